// File: rtl/pkt_reg_pkg.sv
// ---------------------------------------------------------------------------
// pkt_reg_pkg
// Shared definitions for the packet capture register block and its AHB-lite
// front end.
//   - Register byte offsets (word aligned)
//   - CTRL / STATUS / IRQ_EN bit indices
//   - HTRANS encodings
//   - sat_inc16 : 16-bit saturating increment helper
// ---------------------------------------------------------------------------
package pkt_reg_pkg;

    localparam int unsigned REG_CTRL      = 32'h00;
    localparam int unsigned REG_STATUS    = 32'h04;
    localparam int unsigned REG_COUNT     = 32'h08;
    localparam int unsigned REG_IRQ_EN    = 32'h0C;
    localparam int unsigned REG_DATA_BASE = 32'h10;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_DROP_BIT   = 1;
    localparam int STAT_VALID_BIT  = 0;
    localparam int STAT_OVF_BIT    = 1;
    localparam int IRQ_VALID_BIT   = 0;
    localparam int IRQ_OVF_BIT     = 1;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ahbl_slave_frontend.sv
// ---------------------------------------------------------------------------
// ahbl_slave_frontend
// Zero-wait AHB-lite slave front end: registers the address phase and
// presents data-phase strobes to a register block.
// Ports:
//   rclk, rstn        clock, asynchronous active-low reset
//   i_hsel, i_haddr, i_htrans, i_hwrite, i_hready   AHB address-phase inputs
//   o_wr_en           write data phase completing this cycle
//   o_rd_en           read data phase in progress this cycle
//   o_addr_q          byte address captured in the address phase
// ---------------------------------------------------------------------------
module ahbl_slave_frontend
    import pkt_reg_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              rclk,
    input  logic              rstn,
    input  logic              i_hsel,
    input  logic [ADDR_W-1:0] i_haddr,
    input  logic [1:0]        i_htrans,
    input  logic              i_hwrite,
    input  logic              i_hready,
    output logic              o_wr_en,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_addr_q
);

    logic              w_active;
    logic              r_wr;
    logic              r_rd;
    logic [ADDR_W-1:0] r_addr;

    assign w_active = i_hsel && (i_htrans == HTRANS_NONSEQ || i_htrans == HTRANS_SEQ);

    // The pipeline only advances when hready is high; a stalled bus keeps
    // the current data phase (and its address) alive.
    always_ff @(posedge rclk or negedge rstn) begin
        if (!rstn) begin
            r_wr   <= 1'b0;
            r_rd   <= 1'b0;
            r_addr <= '0;
        end else if (i_hready) begin
            r_wr <= w_active && i_hwrite;
            r_rd <= w_active && !i_hwrite;
            if (w_active) begin
                r_addr <= i_haddr;
            end
        end
    end

    // A write lands only on the edge that actually ends the data phase.
    assign o_wr_en  = r_wr && i_hready;
    assign o_rd_en  = r_rd;
    assign o_addr_q = r_addr;

endmodule

// File: rtl/pkt_reg_slave.sv
// ---------------------------------------------------------------------------
// pkt_reg_slave
// AHB-lite zero-wait slave holding one captured packet for polling.
// Register map (byte offsets):
//   0x00 CTRL   RW  bit0 enable, bit1 drop_mode
//   0x04 STATUS     bit0 valid, bit1 overflow; writing 0 to a bit clears it
//   0x08 COUNT  RO  [15:0] accepted (wraps), [31:16] dropped (saturates)
//   0x0C IRQ_EN RW  only with PKT_REG_SLAVE_IRQ_EN, otherwise reads 0
//   0x10+4i DATAi RO
// Optional build macro: PKT_REG_SLAVE_IRQ_EN adds the irq output and IRQ_EN.
// Ports:
//   rclk, rstn                      clock, asynchronous active-low reset
//   hsel/haddr/htrans/hwrite/hsize/hwdata/hready   AHB-lite inputs
//   hrdata/hreadyout/hresp          AHB-lite outputs (always ready, OKAY)
//   irq                             level interrupt (macro builds only)
//   pkt_valid/pkt_data/pkt_ready    packet input port
// Packet handshake: a packet transfers on every rclk edge where pkt_valid and
// pkt_ready are both high; pkt_ready never depends on pkt_valid.
// ---------------------------------------------------------------------------
module pkt_reg_slave
    import pkt_reg_pkg::*;
#(
    parameter  int ADDR_W    = 8,
    parameter  int NUM_WORDS = 8,
    localparam int PKT_W     = 32 * NUM_WORDS
) (
    input  logic              rclk,
    input  logic              rstn,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [31:0]       hwdata,
    input  logic              hready,
    output logic [31:0]       hrdata,
    output logic              hreadyout,
    output logic              hresp,
`ifdef PKT_REG_SLAVE_IRQ_EN
    output logic              irq,
`endif
    input  logic              pkt_valid,
    input  logic [PKT_W-1:0]  pkt_data,
    output logic              pkt_ready
);

    logic              w_wr_en;
    logic              w_rd_en;
    logic [ADDR_W-1:0] w_addr_q;
    logic [31:0]       w_waddr;
    logic              w_wr_ctrl;
    logic              w_wr_status;
    logic              w_clr_now;
    logic              w_accept;
    logic              w_load;
    logic              w_drop;
    logic              w_unused;

    logic [1:0]        r_ctrl;
    logic              r_valid;
    logic              r_ovf;
    logic [15:0]       r_acc_cnt;
    logic [15:0]       r_drop_cnt;
    logic [31:0]       r_data [NUM_WORDS];

    ahbl_slave_frontend #(
        .ADDR_W (ADDR_W)
    ) u_frontend (
        .rclk     (rclk),
        .rstn     (rstn),
        .i_hsel   (hsel),
        .i_haddr  (haddr),
        .i_htrans (htrans),
        .i_hwrite (hwrite),
        .i_hready (hready),
        .o_wr_en  (w_wr_en),
        .o_rd_en  (w_rd_en),
        .o_addr_q (w_addr_q)
    );

    // Only word transfers exist here: byte lanes and hsize are ignored.
    assign w_unused = ^{hsize, hwdata[31:2], w_addr_q[1:0]};
    assign w_waddr  = 32'({w_addr_q[ADDR_W-1:2], 2'b00});

    assign hreadyout = 1'b1;
    assign hresp     = 1'b0;

    assign w_wr_ctrl   = w_wr_en && (w_waddr == REG_CTRL);
    assign w_wr_status = w_wr_en && (w_waddr == REG_STATUS);
    assign w_clr_now   = w_wr_status && !hwdata[STAT_VALID_BIT];

    // Backpressure mode lets a packet in during the very cycle software
    // frees the buffer, so a held packet is not delayed by a cycle.
    always_comb begin
        pkt_ready = 1'b0;
        if (r_ctrl[CTRL_ENABLE_BIT]) begin
            pkt_ready = r_ctrl[CTRL_DROP_BIT] || !r_valid || w_clr_now;
        end
    end

    assign w_accept = pkt_valid && pkt_ready;
    assign w_load   = w_accept && (!r_valid || w_clr_now);
    assign w_drop   = w_accept && !w_load;

    always_ff @(posedge rclk or negedge rstn) begin
        if (!rstn) begin
            r_ctrl     <= '0;
            r_valid    <= 1'b0;
            r_ovf      <= 1'b0;
            r_acc_cnt  <= '0;
            r_drop_cnt <= '0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            if (w_wr_ctrl) begin
                r_ctrl <= hwdata[1:0];
            end
            // A capture in the clearing cycle wins over the clear.
            if (w_load) begin
                r_valid   <= 1'b1;
                r_acc_cnt <= r_acc_cnt + 16'd1;
                for (int i = 0; i < NUM_WORDS; i++) begin
                    r_data[i] <= pkt_data[32*i +: 32];
                end
            end else if (w_wr_status && !hwdata[STAT_VALID_BIT]) begin
                r_valid <= 1'b0;
            end
            if (w_drop) begin
                r_ovf      <= 1'b1;
                r_drop_cnt <= sat_inc16(r_drop_cnt);
            end else if (w_wr_status && !hwdata[STAT_OVF_BIT]) begin
                r_ovf <= 1'b0;
            end
        end
    end

`ifdef PKT_REG_SLAVE_IRQ_EN
    logic [1:0] r_irq_en;
    logic       r_irq;

    always_ff @(posedge rclk or negedge rstn) begin
        if (!rstn) begin
            r_irq_en <= '0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_en && (w_waddr == REG_IRQ_EN)) begin
                r_irq_en <= hwdata[1:0];
            end
            r_irq <= (r_valid && r_irq_en[IRQ_VALID_BIT]) ||
                     (r_ovf && r_irq_en[IRQ_OVF_BIT]);
        end
    end

    assign irq = r_irq;
`endif

    // Read data reflects register state before any update on the same edge.
    always_comb begin
        hrdata = '0;
        if (w_rd_en) begin
            if (w_waddr == REG_CTRL) begin
                hrdata = {30'd0, r_ctrl};
            end else if (w_waddr == REG_STATUS) begin
                hrdata = {30'd0, r_ovf, r_valid};
            end else if (w_waddr == REG_COUNT) begin
                hrdata = {r_drop_cnt, r_acc_cnt};
`ifdef PKT_REG_SLAVE_IRQ_EN
            end else if (w_waddr == REG_IRQ_EN) begin
                hrdata = {30'd0, r_irq_en};
`endif
            end else begin
                for (int i = 0; i < NUM_WORDS; i++) begin
                    if (w_waddr == REG_DATA_BASE + (32'(i) << 2)) begin
                        hrdata = r_data[i];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pkt_reg_slave.sv
module tb_pkt_reg_slave;

    localparam int ADDR_W    = 8;
    localparam int NUM_WORDS = 8;
    localparam int PKT_W     = 32 * NUM_WORDS;
`ifdef PKT_REG_SLAVE_IRQ_EN
    localparam int IRQ_CAPS  = 1;
`else
    localparam int IRQ_CAPS  = 0;
`endif

    // ---------------- clock / reset ----------------
    logic              rclk = 1'b0;
    logic              rstn = 1'b0;
    logic              hsel = 1'b0;
    logic [ADDR_W-1:0] haddr = '0;
    logic [1:0]        htrans = 2'b00;
    logic              hwrite = 1'b0;
    logic [2:0]        hsize = 3'b010;
    logic [31:0]       hwdata = '0;
    logic              hready = 1'b1;
    logic [31:0]       hrdata;
    logic              hreadyout;
    logic              hresp;
    logic              pkt_valid = 1'b0;
    logic [PKT_W-1:0]  pkt_data = '0;
    logic              pkt_ready;
`ifdef PKT_REG_SLAVE_IRQ_EN
    logic              irq;
`endif

    always #5 rclk = ~rclk;

    pkt_reg_slave #(
        .ADDR_W    (ADDR_W),
        .NUM_WORDS (NUM_WORDS)
    ) dut (
        .rclk      (rclk),
        .rstn      (rstn),
        .hsel      (hsel),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hwdata    (hwdata),
        .hready    (hready),
        .hrdata    (hrdata),
        .hreadyout (hreadyout),
        .hresp     (hresp),
`ifdef PKT_REG_SLAVE_IRQ_EN
        .irq       (irq),
`endif
        .pkt_valid (pkt_valid),
        .pkt_data  (pkt_data),
        .pkt_ready (pkt_ready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_en, m_dm, m_valid, m_ovf, m_irq;
    bit [1:0]    m_irqen;
    int          m_acc, m_drp;
    logic [31:0] m_data [NUM_WORDS];
    bit          dp_act, dp_wr;
    logic [7:0]  dp_addr;
    bit          t_clr, t_rdy, t_wr, t_load, t_drop, t_irq;
    logic [7:0]  t_wa;

    function automatic logic [31:0] model_read(input logic [7:0] a);
        logic [7:0] w;
        int         idx;
        w = {a[7:2], 2'b00};
        if (w == 8'h00) return {30'd0, m_dm, m_en};
        if (w == 8'h04) return {30'd0, m_ovf, m_valid};
        if (w == 8'h08) return {m_drp[15:0], m_acc[15:0]};
`ifdef PKT_REG_SLAVE_IRQ_EN
        if (w == 8'h0C) return {30'd0, m_irqen};
`endif
        if (w >= 8'h10) begin
            idx = (int'(w) - 16) / 4;
            if (idx < NUM_WORDS) return m_data[idx];
        end
        return 32'd0;
    endfunction

    function automatic bit model_clr();
        return dp_act && dp_wr && hready && ({dp_addr[7:2], 2'b00} == 8'h04) && !hwdata[0];
    endfunction

    function automatic bit model_ready();
        return m_en && (m_dm || !m_valid || model_clr());
    endfunction

    always @(posedge rclk) begin
        if (!rstn) begin
            m_en = 0; m_dm = 0; m_valid = 0; m_ovf = 0; m_irq = 0; m_irqen = 0;
            m_acc = 0; m_drp = 0; dp_act = 0; dp_wr = 0; dp_addr = '0;
            for (int i = 0; i < NUM_WORDS; i++) m_data[i] = '0;
        end else begin
            t_clr  = model_clr();
            t_rdy  = model_ready();
            t_wr   = dp_act && dp_wr && hready;
            t_wa   = {dp_addr[7:2], 2'b00};
            t_irq  = (m_valid && m_irqen[0]) || (m_ovf && m_irqen[1]);
            t_load = pkt_valid && t_rdy && (!m_valid || t_clr);
            t_drop = pkt_valid && t_rdy && !t_load;
            if (t_wr && t_wa == 8'h00) begin
                m_en = hwdata[0];
                m_dm = hwdata[1];
            end
            if (t_wr && t_wa == 8'h04) begin
                if (!hwdata[0]) m_valid = 0;
                if (!hwdata[1]) m_ovf = 0;
            end
`ifdef PKT_REG_SLAVE_IRQ_EN
            if (t_wr && t_wa == 8'h0C) m_irqen = hwdata[1:0];
`endif
            if (t_load) begin
                m_valid = 1;
                m_acc   = (m_acc + 1) % 65536;
                for (int i = 0; i < NUM_WORDS; i++) m_data[i] = pkt_data[32*i +: 32];
            end
            if (t_drop) begin
                m_ovf = 1;
                if (m_drp < 65535) m_drp = m_drp + 1;
            end
            m_irq = t_irq;
            if (hready) begin
                dp_act  = hsel && htrans[1];
                dp_wr   = hwrite;
                dp_addr = haddr;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge rclk) begin
        if (rstn) begin
            check("hreadyout", {31'd0, hreadyout}, 32'd1);
            check("hresp", {31'd0, hresp}, 32'd0);
            check("pkt_ready", {31'd0, pkt_ready}, {31'd0, model_ready()});
            if (dp_act && !dp_wr) check("hrdata", hrdata, model_read(dp_addr));
`ifdef PKT_REG_SLAVE_IRQ_EN
            check("irq", {31'd0, irq}, {31'd0, m_irq});
`endif
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [PKT_W-1:0] make_pkt(input logic [31:0] base);
        logic [PKT_W-1:0] p;
        for (int i = 0; i < NUM_WORDS; i++) p[32*i +: 32] = base + 32'(i);
        return p;
    endfunction

    // Leaves the bus in the data phase; the write lands on the next edge.
    task automatic bus_write(input logic [7:0] a, input logic [31:0] d,
                             input bit pkt_in_dphase = 0, input logic [31:0] pkt_base = 0);
        @(posedge rclk); #1;
        hsel = 1; htrans = 2'b10; hwrite = 1; haddr = a;
        @(posedge rclk); #1;
        hsel = 0; htrans = 2'b00; hwrite = 0; hwdata = d;
        if (pkt_in_dphase) begin
            pkt_data  = make_pkt(pkt_base);
            pkt_valid = 1;
        end
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        @(posedge rclk); #1;
        hsel = 1; htrans = 2'b10; hwrite = 0; haddr = a;
        @(posedge rclk); #1;
        hsel = 0; htrans = 2'b00;
        @(negedge rclk);
        d = hrdata;
    endtask

    task automatic read_check(input string name, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    task automatic send_pkt(input logic [31:0] base);
        @(posedge rclk); #1;
        pkt_data  = make_pkt(base);
        pkt_valid = 1;
        @(posedge rclk); #1;
        pkt_valid = 0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        repeat (3) @(posedge rclk);
        #1 rstn = 1;

        // reset values
        read_check("rst_ctrl", 8'h00, 32'h0);
        read_check("rst_status", 8'h04, 32'h0);
        read_check("rst_count", 8'h08, 32'h0);
        read_check("rst_data0", 8'h10, 32'h0);

        // first capture
        bus_write(8'h00, 32'h1);
        send_pkt(32'hA5A5_0000);
        read_check("cap_status", 8'h04, 32'h1);
        for (int i = 0; i < NUM_WORDS; i++)
            read_check($sformatf("cap_data%0d", i), 8'(8'h10 + 4*i), 32'hA5A5_0000 + 32'(i));
        read_check("cap_count", 8'h08, 32'h0000_0001);

        // full buffer with backpressure: held packet enters on the clear cycle
        @(posedge rclk); #1;
        pkt_data  = make_pkt(32'hB000_0000);
        pkt_valid = 1;
        @(negedge rclk);
        check("ready_when_full", {31'd0, pkt_ready}, 32'd0);
        bus_write(8'h04, 32'h0);
        @(posedge rclk); #1;
        pkt_valid = 0;
        read_check("clr_cap_status", 8'h04, 32'h1);
        read_check("clr_cap_data0", 8'h10, 32'hB000_0000);
        read_check("clr_cap_data7", 8'h2C, 32'hB000_0007);
        read_check("clr_cap_count", 8'h08, 32'h0000_0002);

        // drop mode while full
        bus_write(8'h00, 32'h3);
        send_pkt(32'hC000_0000);
        send_pkt(32'hC100_0000);
        send_pkt(32'hC200_0000);
        read_check("drop_data0", 8'h10, 32'hB000_0000);
        read_check("drop_status", 8'h04, 32'h3);
        read_check("drop_count", 8'h08, 32'h0003_0002);
        bus_write(8'h04, 32'h0);
        read_check("drop_clr_status", 8'h04, 32'h0);

        // CTRL write with a capture in the same cycle uses the old CTRL
        bus_write(8'h00, 32'h0, 1, 32'hD000_0000);
        @(posedge rclk); #1;
        pkt_valid = 0;
        read_check("ctrlwr_status", 8'h04, 32'h1);
        read_check("ctrlwr_data0", 8'h10, 32'hD000_0000);
        read_check("ctrlwr_ctrl", 8'h00, 32'h0);

        // disabled: packet blocked, contents retained
        send_pkt(32'hE000_0000);
        read_check("dis_data1", 8'h14, 32'hD000_0001);
        read_check("dis_count", 8'h08, 32'h0003_0003);

        // read-only / undecoded space
        bus_write(8'h08, 32'hFFFF_FFFF);
        read_check("count_ro", 8'h08, 32'h0003_0003);
        read_check("undecoded", 8'h40, 32'h0);
        bus_write(8'h0C, 32'h3);
        read_check("irq_en_reg", 8'h0C, IRQ_CAPS ? 32'h3 : 32'h0);
        bus_write(8'h0C, 32'h0);

`ifdef PKT_REG_SLAVE_IRQ_EN
        bus_write(8'h04, 32'h0);
        bus_write(8'h0C, 32'h1);
        bus_write(8'h00, 32'h1);
        send_pkt(32'hF000_0000);
        @(negedge rclk);
        check("irq_lag", {31'd0, irq}, 32'd0);
        @(negedge rclk);
        check("irq_rise", {31'd0, irq}, 32'd1);
        bus_write(8'h04, 32'h0);
        @(posedge rclk);
        @(negedge rclk);
        check("irq_hold", {31'd0, irq}, 32'd1);
        @(negedge rclk);
        check("irq_fall", {31'd0, irq}, 32'd0);
        bus_write(8'h0C, 32'h0);
`endif

        // dropped counter saturation
        bus_write(8'h04, 32'h0);
        bus_write(8'h00, 32'h3);
        send_pkt(32'h9000_0000);
        @(posedge rclk); #1;
        pkt_data  = make_pkt(32'h9900_0000);
        pkt_valid = 1;
        repeat (65540) @(posedge rclk);
        #1 pkt_valid = 0;
        read_check("sat_count", 8'h08, {16'hFFFF, 16'(4 + IRQ_CAPS)});
        read_check("sat_status", 8'h04, 32'h3);
        read_check("sat_data0", 8'h10, 32'h9000_0000);

        // reset during a read data phase
        @(posedge rclk); #1;
        hsel = 1; htrans = 2'b10; hwrite = 0; haddr = 8'h10;
        @(posedge rclk); #1;
        hsel = 0; htrans = 2'b00;
        #2 rstn = 0;
        @(posedge rclk); #1;
        rstn = 1;
        @(negedge rclk);
        check("rst_mid_hrdata", hrdata, 32'h0);
        read_check("rst2_ctrl", 8'h00, 32'h0);
        read_check("rst2_status", 8'h04, 32'h0);
        read_check("rst2_count", 8'h08, 32'h0);
        read_check("rst2_data0", 8'h10, 32'h0);

        repeat (2) @(posedge rclk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
